// File: rtl/z80fi_insn_collector_if.sv
// Event bus from the Z80 core into the instruction collector, plus the
// retirement record it presents to the z80fi checkers.
interface z80fi_insn_collector_if #(
    parameter int MAX_INSN_LEN = 4
);
    logic                      ev_start;
    logic [127:0]              ev_regs;
    logic                      ev_fetch;
    logic [7:0]                ev_fetch_data;
    logic                      ev_rd;
    logic [15:0]               ev_rd_addr;
    logic [7:0]                ev_rd_data;
    logic                      ev_wr;
    logic [15:0]               ev_wr_addr;
    logic [7:0]                ev_wr_data;
    logic                      ev_done;

    logic                      z80fi_valid;
    logic [8*MAX_INSN_LEN-1:0] z80fi_insn;
    logic [2:0]                z80fi_insn_len;
    logic [127:0]              z80fi_regs_in;
    logic [127:0]              z80fi_regs_out;
    logic [1:0]                z80fi_mem_rd_cnt;
    logic [1:0]                z80fi_mem_wr_cnt;
    logic [31:0]               z80fi_mem_raddr;
    logic [15:0]               z80fi_mem_rdata;
    logic [31:0]               z80fi_mem_waddr;
    logic [15:0]               z80fi_mem_wdata;
    logic                      z80fi_overflow;
    logic                      z80fi_dropped;

    modport master (
        output ev_start, ev_regs, ev_fetch, ev_fetch_data, ev_rd, ev_rd_addr,
               ev_rd_data, ev_wr, ev_wr_addr, ev_wr_data, ev_done,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in,
               z80fi_regs_out, z80fi_mem_rd_cnt, z80fi_mem_wr_cnt,
               z80fi_mem_raddr, z80fi_mem_rdata, z80fi_mem_waddr,
               z80fi_mem_wdata, z80fi_overflow, z80fi_dropped
    );

    modport slave (
        input  ev_start, ev_regs, ev_fetch, ev_fetch_data, ev_rd, ev_rd_addr,
               ev_rd_data, ev_wr, ev_wr_addr, ev_wr_data, ev_done,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in,
               z80fi_regs_out, z80fi_mem_rd_cnt, z80fi_mem_wr_cnt,
               z80fi_mem_raddr, z80fi_mem_rdata, z80fi_mem_waddr,
               z80fi_mem_wdata, z80fi_overflow, z80fi_dropped
    );
endinterface

// File: rtl/z80fi_insn_collector.sv
// Assembles one retirement record per executed Z80 instruction (or repeat
// iteration) from core event strobes and emits it as a one-cycle packet.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no record open; only ev_start is honoured
//   COLLECT | record open; fetch/rd/wr accumulate until ev_done retires it
module z80fi_insn_collector #(
    parameter int MAX_INSN_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    z80fi_insn_collector_if.slave bus
);
    typedef enum logic {IDLE, COLLECT} state_t;

    typedef struct packed {
        logic [8*MAX_INSN_LEN-1:0] insn;
        logic [2:0]                len;
        logic [127:0]              regs_in;
        logic [1:0]                rd_cnt;
        logic [31:0]               raddr;
        logic [15:0]               rdata;
        logic [1:0]                wr_cnt;
        logic [31:0]               waddr;
        logic [15:0]               wdata;
        logic                      ovf;
    } rec_t;

    state_t       state_q, state_d;
    rec_t         work_q, work_d;
    rec_t         out_q;
    rec_t         cur_ev, fresh, fresh_ev;
    logic [127:0] regs_out_q;
    logic         valid_q, dropped_q;
    logic         emit, drop;

    // Folds this cycle's fetch/rd/wr strobes into a record; full limits only flag overflow.
    function automatic rec_t add_events(rec_t r);
        rec_t o;
        o = r;
        if (bus.ev_fetch) begin
            if (o.len == 3'(MAX_INSN_LEN)) begin
                o.ovf = 1'b1;
            end else begin
                for (int i = 0; i < MAX_INSN_LEN; i++) begin
                    if (o.len == 3'(i)) o.insn[i*8 +: 8] = bus.ev_fetch_data;
                end
                o.len = o.len + 3'd1;
            end
        end
        if (bus.ev_rd) begin
            if (o.rd_cnt == 2'd2) begin
                o.ovf = 1'b1;
            end else begin
                if (o.rd_cnt == 2'd0) begin
                    o.raddr[15:0] = bus.ev_rd_addr;
                    o.rdata[7:0]  = bus.ev_rd_data;
                end else begin
                    o.raddr[31:16] = bus.ev_rd_addr;
                    o.rdata[15:8]  = bus.ev_rd_data;
                end
                o.rd_cnt = o.rd_cnt + 2'd1;
            end
        end
        if (bus.ev_wr) begin
            if (o.wr_cnt == 2'd2) begin
                o.ovf = 1'b1;
            end else begin
                if (o.wr_cnt == 2'd0) begin
                    o.waddr[15:0] = bus.ev_wr_addr;
                    o.wdata[7:0]  = bus.ev_wr_data;
                end else begin
                    o.waddr[31:16] = bus.ev_wr_addr;
                    o.wdata[15:8]  = bus.ev_wr_data;
                end
                o.wr_cnt = o.wr_cnt + 2'd1;
            end
        end
        return o;
    endfunction

    always_comb begin
        cur_ev        = add_events(work_q);
        fresh         = '0;
        fresh.regs_in = bus.ev_regs;
        fresh_ev      = add_events(fresh);

        state_d = state_q;
        work_d  = work_q;
        emit    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ev_start) begin
                    work_d  = fresh_ev;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.ev_done) begin
                    // Same-cycle events belong to the retiring record, so a
                    // back-to-back successor opens with empty counters.
                    emit = 1'b1;
                    if (bus.ev_start) work_d = fresh;
                    else              state_d = IDLE;
                end else if (bus.ev_start) begin
                    drop   = 1'b1;
                    work_d = fresh_ev;
                end else begin
                    work_d = cur_ev;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            out_q      <= '0;
            regs_out_q <= '0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            valid_q   <= emit;
            dropped_q <= drop;
            if (emit) begin
                out_q      <= cur_ev;
                regs_out_q <= bus.ev_regs;
            end
        end
    end

    assign bus.z80fi_valid      = valid_q;
    assign bus.z80fi_dropped    = dropped_q;
    assign bus.z80fi_insn       = out_q.insn;
    assign bus.z80fi_insn_len   = out_q.len;
    assign bus.z80fi_regs_in    = out_q.regs_in;
    assign bus.z80fi_regs_out   = regs_out_q;
    assign bus.z80fi_mem_rd_cnt = out_q.rd_cnt;
    assign bus.z80fi_mem_wr_cnt = out_q.wr_cnt;
    assign bus.z80fi_mem_raddr  = out_q.raddr;
    assign bus.z80fi_mem_rdata  = out_q.rdata;
    assign bus.z80fi_mem_waddr  = out_q.waddr;
    assign bus.z80fi_mem_wdata  = out_q.wdata;
    assign bus.z80fi_overflow   = out_q.ovf;
endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Scoreboard bench for z80fi_insn_collector: expected records are queued as
// each retiring ev_done is driven and compared when z80fi_valid appears.
module tb_z80fi_insn_collector;
    localparam int L = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z80fi_insn_collector_if #(.MAX_INSN_LEN(L)) bus();
    z80fi_insn_collector #(.MAX_INSN_LEN(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int           cyc;
        logic [31:0]  insn;
        logic [2:0]   len;
        logic [127:0] rin;
        logic [127:0] rout;
        logic [1:0]   rdc;
        logic [31:0]  ra;
        logic [15:0]  rd;
        logic [1:0]   wrc;
        logic [31:0]  wa;
        logic [15:0]  wd;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.z80fi_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("valid_unexpected", bus.z80fi_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("valid_cyc", cyc,                  e.cyc);
                    check_eq("insn",      bus.z80fi_insn,       e.insn);
                    check_eq("len",       bus.z80fi_insn_len,   e.len);
                    check_eq("regs_in",   bus.z80fi_regs_in,    e.rin);
                    check_eq("regs_out",  bus.z80fi_regs_out,   e.rout);
                    check_eq("rd_cnt",    bus.z80fi_mem_rd_cnt, e.rdc);
                    check_eq("raddr",     bus.z80fi_mem_raddr,  e.ra);
                    check_eq("rdata",     bus.z80fi_mem_rdata,  e.rd);
                    check_eq("wr_cnt",    bus.z80fi_mem_wr_cnt, e.wrc);
                    check_eq("waddr",     bus.z80fi_mem_waddr,  e.wa);
                    check_eq("wdata",     bus.z80fi_mem_wdata,  e.wd);
                    check_eq("overflow",  bus.z80fi_overflow,   e.ovf);
                end
            end
            if (bus.z80fi_dropped) begin
                if (drop_q.size() == 0) check_eq("dropped_unexpected", bus.z80fi_dropped, 0);
                else                    check_eq("dropped_cyc", cyc, drop_q.pop_front());
            end
        end
    end

    function automatic logic [127:0] mk_regs(logic [7:0] a, logic [15:0] bc,
                                             logic [15:0] hl, logic [15:0] ip);
        return {ip, 16'hFFF0, 16'h5A5A, 16'hA5A5, hl, 16'h1234, bc, 8'h44, a};
    endfunction

    task automatic clear_ev();
        bus.ev_start = 0; bus.ev_fetch = 0; bus.ev_rd = 0; bus.ev_wr = 0; bus.ev_done = 0;
        bus.ev_fetch_data = 0; bus.ev_rd_addr = 0; bus.ev_rd_data = 0;
        bus.ev_wr_addr = 0; bus.ev_wr_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ev();
    endtask

    task automatic do_start(logic [127:0] r);
        bus.ev_start = 1; bus.ev_regs = r; tick();
    endtask
    task automatic do_fetch(logic [7:0] b);
        bus.ev_fetch = 1; bus.ev_fetch_data = b; tick();
    endtask
    task automatic do_rd(logic [15:0] a, logic [7:0] d);
        bus.ev_rd = 1; bus.ev_rd_addr = a; bus.ev_rd_data = d; tick();
    endtask
    task automatic do_wr(logic [15:0] a, logic [7:0] d);
        bus.ev_wr = 1; bus.ev_wr_addr = a; bus.ev_wr_data = d; tick();
    endtask
    task automatic do_done(logic [127:0] r);
        bus.ev_done = 1; bus.ev_regs = r; tick();
    endtask

    // Called in the drive slot of the retiring cycle; valid is due one cycle later.
    task automatic push_exp(logic [31:0] insn, logic [2:0] len, logic [127:0] rin,
                            logic [127:0] rout, logic [1:0] rdc, logic [31:0] ra,
                            logic [15:0] rd, logic [1:0] wrc, logic [31:0] wa,
                            logic [15:0] wd, logic ovf);
        exp_t e;
        e.cyc = cyc + 1; e.insn = insn; e.len = len; e.rin = rin; e.rout = rout;
        e.rdc = rdc; e.ra = ra; e.rd = rd; e.wrc = wrc; e.wa = wa; e.wd = wd; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [127:0] pre, post, r0, r1, r2;
        reset_n = 0;
        bus.ev_regs = '0;
        clear_ev();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid",  bus.z80fi_valid, 0);
        check_eq("rst_record", {bus.z80fi_insn, bus.z80fi_insn_len, bus.z80fi_mem_rd_cnt,
                                bus.z80fi_mem_wr_cnt, bus.z80fi_overflow, bus.z80fi_dropped}, 0);
        check_eq("rst_regs",   bus.z80fi_regs_out | bus.z80fi_regs_in, 0);
        reset_n = 1;

        // CPDR, single iteration
        pre  = mk_regs(8'h42, 16'h0002, 16'h1000, 16'h0100);
        post = mk_regs(8'h42, 16'h0001, 16'h0FFF, 16'h0100);
        do_start(pre);
        do_fetch(8'hED);
        do_fetch(8'hB9);
        do_rd(16'h1000, 8'h40);
        push_exp(32'h0000B9ED, 3'd2, pre, post, 2'd1, 32'h00001000, 16'h0040, 2'd0, 0, 0, 1'b0);
        do_done(post);

        // CPDR, three repeat iterations
        for (int it = 0; it < 3; it++) begin
            pre  = mk_regs(8'h42, 16'(3 - it), 16'(16'h2000 - it), 16'h0200);
            post = mk_regs(8'h42, 16'(2 - it), 16'(16'h1FFF - it), 16'h0200);
            do_start(pre);
            do_fetch(8'hED);
            do_fetch(8'hB9);
            do_rd(16'(16'h2000 - it), 8'(8'h10 + it));
            push_exp(32'h0000B9ED, 3'd2, pre, post, 2'd1, {16'h0, 16'(16'h2000 - it)},
                     {8'h0, 8'(8'h10 + it)}, 2'd0, 0, 0, 1'b0);
            do_done(post);
        end

        // done + start + rd together; then a record with two writes, the last alongside done
        r0 = mk_regs(8'h01, 16'h0005, 16'h2100, 16'h0300);
        r1 = mk_regs(8'h02, 16'h0004, 16'h2101, 16'h0302);
        r2 = mk_regs(8'h02, 16'h0004, 16'h2101, 16'h0303);
        do_start(r0);
        do_fetch(8'hED);
        do_fetch(8'hA1);
        bus.ev_done = 1; bus.ev_start = 1; bus.ev_regs = r1;
        bus.ev_rd = 1; bus.ev_rd_addr = 16'h2100; bus.ev_rd_data = 8'h55;
        push_exp(32'h0000A1ED, 3'd2, r0, r1, 2'd1, 32'h00002100, 16'h0055, 2'd0, 0, 0, 1'b0);
        tick();
        do_fetch(8'h77);
        do_wr(16'h3000, 8'h42);
        bus.ev_wr = 1; bus.ev_wr_addr = 16'h3001; bus.ev_wr_data = 8'h43;
        push_exp(32'h00000077, 3'd1, r1, r2, 2'd0, 0, 0, 2'd2, 32'h30013000, 16'h4342, 1'b0);
        do_done(r2);

        // Overflow: five bytes, three reads
        pre  = mk_regs(8'h10, 16'h0000, 16'h4000, 16'h0400);
        post = mk_regs(8'h11, 16'h0000, 16'h4000, 16'h0404);
        do_start(pre);
        do_fetch(8'hDD); do_fetch(8'hCB); do_fetch(8'h05); do_fetch(8'h06); do_fetch(8'h07);
        do_rd(16'h4000, 8'h11); do_rd(16'h4001, 8'h22); do_rd(16'h4002, 8'h33);
        push_exp(32'h0605CBDD, 3'd4, pre, post, 2'd2, 32'h40014000, 16'h2211, 2'd0, 0, 0, 1'b1);
        do_done(post);

        // Abandon: second start carries a fetch that belongs to the new record
        r0 = mk_regs(8'h20, 16'h0000, 16'h0000, 16'h0500);
        r1 = mk_regs(8'h21, 16'h0000, 16'h0000, 16'h0501);
        r2 = mk_regs(8'h12, 16'h0000, 16'h0000, 16'h0503);
        do_start(r0);
        do_fetch(8'h00);
        bus.ev_start = 1; bus.ev_regs = r1; bus.ev_fetch = 1; bus.ev_fetch_data = 8'h3E;
        drop_q.push_back(cyc + 1);
        tick();
        do_fetch(8'h12);
        push_exp(32'h0000123E, 3'd2, r1, r2, 2'd0, 0, 0, 2'd0, 0, 0, 1'b0);
        do_done(r2);
        tick();

        // Reset mid-record
        do_start(mk_regs(8'h30, 16'h0, 16'h0, 16'h0600));
        do_fetch(8'h01);
        #2 reset_n = 0;
        #1;
        check_eq("midrst_valid",  {bus.z80fi_valid, bus.z80fi_dropped}, 0);
        check_eq("midrst_record", {bus.z80fi_insn, bus.z80fi_insn_len, bus.z80fi_mem_rd_cnt,
                                   bus.z80fi_mem_raddr, bus.z80fi_mem_rdata, bus.z80fi_overflow}, 0);
        check_eq("midrst_regs",   {bus.z80fi_regs_in, bus.z80fi_regs_out}, 0);
        @(posedge clk);
        #1 reset_n = 1;
        bus.ev_fetch = 1; bus.ev_fetch_data = 8'h99;
        do_done(mk_regs(8'h31, 16'h0, 16'h0, 16'h0603));
        do_fetch(8'hFF);

        // Normal record after reset; the idle fetch above must not appear
        r0 = mk_regs(8'h40, 16'h0, 16'h0, 16'h0700);
        r1 = mk_regs(8'h40, 16'h0, 16'h0, 16'h0701);
        do_start(r0);
        do_fetch(8'h00);
        push_exp(32'h00000000, 3'd1, r0, r1, 2'd0, 0, 0, 2'd0, 0, 0, 1'b0);
        do_done(r1);

        repeat (4) tick();
        check_eq("exp_q_left",  exp_q.size(), 0);
        check_eq("drop_q_left", drop_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
